// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps on unsupported opcodes and counts retired instructions.
module multicycle_control #(
    parameter int          ALUOP_W   = 3,
    parameter int          CNT_W     = 32,
    parameter logic [6:0]  OP_LOAD   = 7'b0000011,
    parameter logic [6:0]  OP_STORE  = 7'b0100011,
    parameter logic [6:0]  OP_RTYPE  = 7'b0110011,
    parameter logic [6:0]  OP_ITYPE  = 7'b0010011,
    parameter logic [6:0]  OP_BRANCH = 7'b1100011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state,
    output logic               illegal,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXR    = 4'd6,
        S_EXI    = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = '0;
        illegal    = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut here.
                alu_src_b = 2'b10;
                if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)                 state_d = S_EXR;
                else if (opcode == OP_ITYPE)                 state_d = S_EXI;
                else if (opcode == OP_BRANCH)                state_d = S_BRANCH;
                else                                         state_d = S_TRAP;
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXR: begin
                alu_src_a = 2'b01;
                alu_op    = ALUOP_W'(3'b010);
                state_d   = S_ALUWB;
            end
            S_EXI: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_W'(3'b011);
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = ALUOP_W'(3'b001);
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
        // Reset must block every side effect of the aborted instruction.
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            ir_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = '0;
            illegal    = 1'b0;
            retire     = 1'b0;
        end
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign state       = state_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected outputs,
// a monitor pops and compares at the falling edge.
module tb_multicycle_control;

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_X = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, branch, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write;
    logic [1:0] alu_src_a, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal, retire;
    logic [3:0] retired_cnt;

    multicycle_control #(.ALUOP_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .illegal(illegal), .retire(retire),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, br, irw, iod, mrd, mwr, m2r, rw;
        logic [1:0] sa, sb;
        logic [2:0] op;
        logic ill, ret;
        logic [3:0] st;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        exp_t  e;
        string nm;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;
    logic [3:0] exp_cnt = 4'd0;

    // Hand-written output table per state code.
    function automatic exp_t table_out(input logic [3:0] st, input logic mr, input logic rst,
                                       input logic [3:0] cnt);
        exp_t e;
        e = '0;
        e.st  = st;
        e.cnt = cnt;
        if (!rst) begin
            case (st)
                4'd0:  begin e.pcw = mr; e.irw = mr; e.mrd = 1'b1; e.sb = 2'b01; end
                4'd1:  begin e.sb = 2'b10; end
                4'd2:  begin e.sa = 2'b01; e.sb = 2'b10; end
                4'd3:  begin e.mrd = 1'b1; e.iod = 1'b1; end
                4'd4:  begin e.rw = 1'b1; e.m2r = 1'b1; e.ret = 1'b1; end
                4'd5:  begin e.mwr = 1'b1; e.iod = 1'b1; e.ret = mr; end
                4'd6:  begin e.sa = 2'b01; e.op = 3'b010; end
                4'd7:  begin e.sa = 2'b01; e.sb = 2'b10; e.op = 3'b011; end
                4'd8:  begin e.rw = 1'b1; e.ret = 1'b1; end
                4'd9:  begin e.sa = 2'b01; e.op = 3'b001; e.br = 1'b1; e.ret = 1'b1; end
                4'd10: begin e.ill = 1'b1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic [6:0] op, input logic mr,
                       input logic [3:0] st, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        it.e  = table_out(st, mr, rst, exp_cnt);
        it.nm = nm;
        q.push_back(it);
        if (rst)           exp_cnt = 4'd0;
        else if (it.e.ret) exp_cnt = exp_cnt + 4'd1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t  a;
            it = q.pop_front();
            a = '{pcw: pc_write, br: branch, irw: ir_write, iod: i_or_d, mrd: mem_read,
                  mwr: mem_write, m2r: mem_to_reg, rw: reg_write, sa: alu_src_a,
                  sb: alu_src_b, op: alu_op, ill: illegal, ret: retire, st: state,
                  cnt: retired_cnt};
            total++;
            if (a !== it.e) begin
                bad++;
                $display("FAIL %s t=%0t actual=%h required=%h (state %0d vs %0d, cnt %0d vs %0d)",
                         it.nm, $time, a, it.e, a.st, it.e.st, a.cnt, it.e.cnt);
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = OP_R; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        cyc(1, OP_R, 1, 4'd0, "reset_hold");
        // R-type, no stalls: 0,1,6,8
        cyc(0, OP_R, 1, 4'd0, "r_fetch");
        cyc(0, OP_R, 1, 4'd1, "r_decode");
        cyc(0, OP_R, 1, 4'd6, "r_exr");
        cyc(0, OP_R, 1, 4'd8, "r_aluwb");
        // I-type with a fetch stall
        cyc(0, OP_I, 0, 4'd0, "i_fetch_stall");
        cyc(0, OP_I, 1, 4'd0, "i_fetch");
        cyc(0, OP_I, 1, 4'd1, "i_decode");
        cyc(0, OP_I, 0, 4'd7, "i_exi");
        cyc(0, OP_I, 0, 4'd8, "i_aluwb");
        // lb with 3 stall cycles in MEMRD
        cyc(0, OP_L, 1, 4'd0, "lb_fetch");
        cyc(0, OP_L, 1, 4'd1, "lb_decode");
        cyc(0, OP_L, 1, 4'd2, "lb_memadr");
        for (int i = 0; i < 3; i++) cyc(0, OP_L, 0, 4'd3, "lb_memrd_stall");
        cyc(0, OP_L, 1, 4'd3, "lb_memrd");
        cyc(0, OP_L, 0, 4'd4, "lb_memwb");
        // sb with one write stall, then plain sb
        cyc(0, OP_S, 1, 4'd0, "sb_fetch");
        cyc(0, OP_S, 1, 4'd1, "sb_decode");
        cyc(0, OP_S, 1, 4'd2, "sb_memadr");
        cyc(0, OP_S, 0, 4'd5, "sb_memwr_stall");
        cyc(0, OP_S, 1, 4'd5, "sb_memwr");
        cyc(0, OP_S, 1, 4'd0, "sb2_fetch");
        cyc(0, OP_S, 1, 4'd1, "sb2_decode");
        cyc(0, OP_S, 1, 4'd2, "sb2_memadr");
        cyc(0, OP_S, 1, 4'd5, "sb2_memwr");
        // reset in MEMRD with mem_ready=1 aborts the load
        cyc(0, OP_L, 1, 4'd0, "abort_fetch");
        cyc(0, OP_L, 1, 4'd1, "abort_decode");
        cyc(0, OP_L, 1, 4'd2, "abort_memadr");
        cyc(1, OP_L, 1, 4'd3, "abort_reset_memrd");
        cyc(0, OP_L, 0, 4'd0, "abort_after");
        cyc(0, OP_B, 1, 4'd0, "abort_refetch");
        // 16 bne retires: counter 0 -> 15 -> 0
        for (int i = 0; i < 16; i++) begin
            if (i > 0) cyc(0, OP_B, 1, 4'd0, "bne_fetch");
            cyc(0, OP_B, 1, 4'd1, "bne_decode");
            cyc(0, OP_B, 1, 4'd9, "bne_branch");
        end
        cyc(0, OP_X, 1, 4'd0, "bne_wrap_fetch");
        // illegal opcode: absorbing TRAP, mem_ready ignored
        cyc(0, OP_X, 1, 4'd1, "trap_decode");
        for (int i = 0; i < 10; i++) cyc(0, OP_X, 1'(i), 4'd10, "trap_hold");
        cyc(1, OP_X, 1, 4'd10, "trap_reset");
        cyc(0, OP_R, 1, 4'd0, "trap_exit_fetch");
        cyc(0, OP_R, 1, 4'd1, "trap_exit_decode");

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
